// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - instruction, preload, debug and ALU signals of the operand fetch stage
// The master side supplies instructions and ALU results; the slave side is operand_fetch.
interface operand_fetch_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        ld_we;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_opcode;
  logic        alu_valid;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;

  modport master (
    output instr_valid, instr, ld_we, ld_addr, ld_data, dbg_addr, alu_c, alu_flags,
    input  instr_ready, dbg_data, alu_a, alu_b, alu_opcode, alu_valid, psr
  );

  modport slave (
    input  instr_valid, instr, ld_we, ld_addr, ld_data, dbg_addr, alu_c, alu_flags,
    output instr_ready, dbg_data, alu_a, alu_b, alu_opcode, alu_valid, psr
  );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register file, decode and operand staging for a 16-bit ALU
// One instruction in flight: IDLE -> DECODE -> EXEC -> WB, illegal words drop back from DECODE.
module operand_fetch (
  input  logic          clk,
  input  logic          reset_n,
  operand_fetch_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] WB     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] instr_q;
  logic [15:0] rf_q [16];
  logic [4:0]  psr_q;
  logic [15:0] alu_a_q, alu_b_q;
  logic [7:0]  alu_opcode_q;
  logic        alu_valid_q;

  logic [3:0] op, rdest, ext, rsrc;
  logic [7:0] imm;
  assign op    = instr_q[15:12];
  assign rdest = instr_q[11:8];
  assign ext   = instr_q[7:4];
  assign rsrc  = instr_q[3:0];
  assign imm   = instr_q[7:0];

  logic is_rr, rr_legal, imm_legal, legal, sign_imm, is_cmp, psr_upd;
  logic [15:0] operand_b;

  always_comb begin
    is_rr     = (op == 4'h0);
    rr_legal  = 1'b0;
    imm_legal = 1'b0;
    sign_imm  = 1'b0;
    case (ext)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: rr_legal = is_rr;
      default:                                   rr_legal = 1'b0;
    endcase
    case (op)
      4'h1, 4'h2, 4'h3, 4'hD, 4'hF: imm_legal = 1'b1;
      4'h5, 4'h9, 4'hB: begin
        imm_legal = 1'b1;
        sign_imm  = 1'b1;
      end
      default: imm_legal = 1'b0;
    endcase
    legal   = rr_legal | imm_legal;
    is_cmp  = is_rr ? (ext == 4'hB) : (op == 4'hB);
    // Only the arithmetic group (add, subtract, compare) produces flags worth keeping.
    psr_upd = is_rr ? (ext == 4'h5 || ext == 4'h9 || ext == 4'hB) : sign_imm;
    if (is_rr)
      operand_b = rf_q[rsrc];
    else if (sign_imm)
      operand_b = {{8{imm[7]}}, imm};
    else
      operand_b = {8'h00, imm};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.instr_valid) state_d = DECODE;
      DECODE:  state_d = legal ? EXEC : IDLE;
      EXEC:    state_d = WB;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      psr_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_valid_q  <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      alu_valid_q <= (state_q == DECODE) && legal;
      if (state_q == IDLE && bus.instr_valid)
        instr_q <= bus.instr;
      // A preload in the accept cycle lands before DECODE reads the file.
      if (state_q == IDLE && bus.ld_we)
        rf_q[bus.ld_addr] <= bus.ld_data;
      if (state_q == DECODE && legal) begin
        alu_a_q      <= rf_q[rdest];
        alu_b_q      <= operand_b;
        alu_opcode_q <= {op, ext};
      end
      if (state_q == WB) begin
        if (!is_cmp) rf_q[rdest] <= bus.alu_c;
        if (psr_upd) psr_q <= bus.alu_flags;
      end
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.dbg_data    = rf_q[bus.dbg_addr];
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_valid   = alu_valid_q;
  assign bus.psr         = psr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - randomized self-checking bench for operand_fetch
// An architectural register/psr model predicts operands, writeback and flags per instruction.
`timescale 1ns/100ps
module tb_operand_fetch;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_if ofi ();

  operand_fetch dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ofi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ref_rf [16];
  logic [4:0]  ref_psr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result of each mnemonic; the ALU stand-in and the model both use it.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [3:0] ext,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [3:0] sel;
    sel = (op == 4'h0) ? ext : op;
    case (sel)
      4'h1:    alu_fn = a & b;
      4'h2:    alu_fn = a | b;
      4'h3:    alu_fn = a ^ b;
      4'h5:    alu_fn = a + b;
      4'h9:    alu_fn = a - b;
      4'hB:    alu_fn = a - b;
      4'hD:    alu_fn = b;
      4'hF:    alu_fn = (op == 4'h0) ? 16'h0 : {b[7:0], 8'h00};
      default: alu_fn = 16'h0;
    endcase
  endfunction

  always_comb ofi.alu_c = alu_fn(ofi.alu_opcode[7:4], ofi.alu_opcode[3:0], ofi.alu_a, ofi.alu_b);

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0;
    ref_psr = 5'h0;
  endtask

  task automatic idle_inputs();
    ofi.instr_valid = 1'b0;
    ofi.instr       = 16'h0;
    ofi.ld_we       = 1'b0;
    ofi.ld_addr     = 4'h0;
    ofi.ld_data     = 16'h0;
  endtask

  task automatic sweep_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      ofi.dbg_addr = 4'(i);
      #0.2;
      check_eq($sformatf("%s_R%0d", tag, i), {16'h0, ofi.dbg_data}, {16'h0, ref_rf[i]});
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    ofi.ld_we = 1'b1; ofi.ld_addr = a; ofi.ld_data = d;
    @(posedge clk); #1;
    ofi.ld_we = 1'b0;
    ref_rf[a] = d;
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [4:0] flg,
                           input bit ld_en, input logic [3:0] la, input logic [15:0] ld);
    logic [3:0] op, ext, rd, rs;
    logic [7:0] imm;
    bit legal, rr, sx, wr, upd;
    logic [15:0] ea, eb, res;
    int guard;
    @(posedge clk); #1;
    guard = 0;
    while (!ofi.instr_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ofi.instr_ready) check_eq("ready_wait", 0, 1);
    ofi.alu_flags = flg;
    ofi.instr = ins; ofi.instr_valid = 1'b1;
    ofi.ld_we = ld_en; ofi.ld_addr = la; ofi.ld_data = ld;
    @(posedge clk); #1;                                   // e0
    idle_inputs();
    if (ld_en) ref_rf[la] = ld;
    check_eq("ready_after_accept", {31'h0, ofi.instr_ready}, 0);

    op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; rs = ins[3:0]; imm = ins[7:0];
    rr = (op == 4'h0);
    legal = rr ? (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD})
               : (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF});
    sx  = !rr && (op inside {4'h5, 4'h9, 4'hB});
    ea  = ref_rf[rd];
    eb  = rr ? ref_rf[rs] : (sx ? {{8{imm[7]}}, imm} : {8'h00, imm});
    res = alu_fn(op, ext, ea, eb);
    wr  = !(rr ? (ext == 4'hB) : (op == 4'hB));
    upd = rr ? (ext inside {4'h5, 4'h9, 4'hB}) : sx;

    @(posedge clk); #1;                                   // e1
    if (!legal) begin
      check_eq("illegal_no_valid", {31'h0, ofi.alu_valid}, 0);
      check_eq("illegal_ready", {31'h0, ofi.instr_ready}, 1);
      check_eq("illegal_psr", {27'h0, ofi.psr}, {27'h0, ref_psr});
      return;
    end
    check_eq("exec_valid", {31'h0, ofi.alu_valid}, 1);
    check_eq("exec_alu_a", {16'h0, ofi.alu_a}, {16'h0, ea});
    check_eq("exec_alu_b", {16'h0, ofi.alu_b}, {16'h0, eb});
    check_eq("exec_opcode", {24'h0, ofi.alu_opcode}, {24'h0, op, ext});
    // Traffic that must be ignored while busy.
    ofi.instr_valid = 1'($urandom_range(1)); ofi.instr = 16'($urandom);
    ofi.ld_we = 1'($urandom_range(1)); ofi.ld_addr = 4'($urandom); ofi.ld_data = 16'($urandom);
    @(posedge clk); #1;                                   // e2
    check_eq("wb_valid_low", {31'h0, ofi.alu_valid}, 0);
    check_eq("wb_alu_a_hold", {16'h0, ofi.alu_a}, {16'h0, ea});
    #3;
    idle_inputs();
    @(posedge clk); #1;                                   // e3
    if (wr) ref_rf[rd] = res;
    if (upd) ref_psr = flg;
    check_eq("done_ready", {31'h0, ofi.instr_ready}, 1);
    check_eq("done_psr", {27'h0, ofi.psr}, {27'h0, ref_psr});
    ofi.dbg_addr = rd;
    #0.2;
    check_eq("done_rdest", {16'h0, ofi.dbg_data}, {16'h0, ref_rf[rd]});
  endtask

  function automatic logic [4:0] new_flags();
    logic [4:0] f;
    f = 5'($urandom);
    if (f == ref_psr) f = f ^ 5'h1;
    return f;
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [3:0] rr_ext [7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    logic [3:0] im_op [8]  = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};
    int k;
    k = $urandom_range(3);
    if (k == 0) return 16'($urandom);
    if (k == 1) return {4'h0, 4'($urandom), rr_ext[$urandom_range(6)], 4'($urandom)};
    return {im_op[$urandom_range(7)], 4'($urandom), 8'($urandom)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ref_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    ofi.dbg_addr = 4'h0;
    ofi.alu_flags = 5'h0;
    ref_reset();

    #2;
    check_eq("rst_ready", {31'h0, ofi.instr_ready}, 1);
    check_eq("rst_valid", {31'h0, ofi.alu_valid}, 0);
    check_eq("rst_alu_a", {16'h0, ofi.alu_a}, 0);
    check_eq("rst_alu_b", {16'h0, ofi.alu_b}, 0);
    check_eq("rst_opcode", {24'h0, ofi.alu_opcode}, 0);
    check_eq("rst_psr", {27'h0, ofi.psr}, 0);
    sweep_regs("rst");
    @(negedge clk);
    reset_n = 1'b1;

    preload(4'd1, 16'h0005);
    run_instr(16'h51FF, new_flags(), 0, 4'h0, 16'h0);
    check_eq("addi_r1", {16'h0, ref_rf[1]}, 32'h0004);

    preload(4'd2, 16'h0F0F);
    run_instr(16'h12F0, new_flags(), 0, 4'h0, 16'h0);
    check_eq("andi_r2", {16'h0, ref_rf[2]}, 32'h0000);

    do_reset();
    preload(4'd3, 16'd10);
    preload(4'd4, 16'd20);
    run_instr(16'h03B4, new_flags(), 0, 4'h0, 16'h0);
    check_eq("cmp_r3", {16'h0, ref_rf[3]}, 32'd10);

    run_instr(16'h4000, new_flags(), 0, 4'h0, 16'h0);
    sweep_regs("illegal");

    run_instr(16'h0776, new_flags(), 1, 4'h7, 16'h1234);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(3) == 0) preload(4'($urandom), 16'($urandom));
      run_instr(rand_instr(), new_flags(), 1'($urandom_range(1)), 4'($urandom), 16'($urandom));
    end
    sweep_regs("random");

    // Held request: one accept every fourth edge.
    preload(4'd5, 16'h0100);
    preload(4'd6, 16'h0011);
    @(posedge clk); #1;
    ofi.alu_flags = new_flags();
    ofi.instr = 16'h0556; ofi.instr_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("b2b_ready_%0d", k), {31'h0, ofi.instr_ready}, (k % 4 == 3) ? 1 : 0);
    end
    ofi.instr_valid = 1'b0;
    ref_rf[5] = 16'h0100 + 3 * 16'h0011;
    ref_psr = ofi.alu_flags;
    check_eq("b2b_psr", {27'h0, ofi.psr}, {27'h0, ref_psr});
    sweep_regs("b2b");

    // Reset while EXEC of an ADD is on the ALU.
    preload(4'd5, 16'h0003);
    preload(4'd6, 16'h0004);
    @(posedge clk); #1;
    ofi.alu_flags = new_flags();
    ofi.instr = 16'h0556; ofi.instr_valid = 1'b1;
    @(posedge clk); #1;
    ofi.instr_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_valid", {31'h0, ofi.alu_valid}, 1);
    reset_n = 1'b0;
    ref_reset();
    #1;
    check_eq("mid_rst_valid", {31'h0, ofi.alu_valid}, 0);
    check_eq("mid_rst_alu_a", {16'h0, ofi.alu_a}, 0);
    check_eq("mid_rst_alu_b", {16'h0, ofi.alu_b}, 0);
    check_eq("mid_rst_opcode", {24'h0, ofi.alu_opcode}, 0);
    check_eq("mid_rst_psr", {27'h0, ofi.psr}, 0);
    check_eq("mid_rst_ready", {31'h0, ofi.instr_ready}, 1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("post_rst_ready", {31'h0, ofi.instr_ready}, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_psr", {27'h0, ofi.psr}, 0);
    sweep_regs("post_rst");
    run_instr(16'hD5A5, new_flags(), 0, 4'h0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

endmodule
